// File: rtl/neg_arbiter_if.sv
// neg_arbiter_if: requester-side bus for the shared 4-bit negator controller
interface neg_arbiter_if;
  logic [1:0] req;
  logic [3:0] a0;
  logic [3:0] a1;
  logic [1:0] mode;
  logic [1:0] gnt;
  logic [3:0] y;
  logic       done;
  logic       ovf;
  modport master (output req, a0, a1, mode, input gnt, y, done, ovf);
  modport slave  (input req, a0, a1, mode, output gnt, y, done, ovf);
endinterface

// File: rtl/neg_arbiter.sv
// neg_arbiter: round-robin sharing of one 4-bit negator between two requesters
module neg_arbiter (
  input  logic          clk,
  input  logic          rst,
  neg_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, INV, INC, DONE} state_t;
  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       md_q, md_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] y_q, y_d;
  logic [1:0] gnt_q, gnt_d;
  logic       ovf_q, ovf_d;
  logic       win;
  // on a tie the requester not served last wins; otherwise the sole requester
  assign win = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    md_d    = md_q;
    opr_d   = opr_q;
    y_d     = y_q;
    gnt_d   = gnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (bus.req != 2'b00) begin
          opr_d   = win ? bus.a1 : bus.a0;
          md_d    = bus.mode[win];
          gnt_d   = win ? 2'b10 : 2'b01;
          ovf_d   = 1'b0;
          state_d = INV;
        end
      end
      INV: begin
        y_d     = ~opr_q;
        state_d = md_q ? INC : DONE;
      end
      INC: begin
        y_d     = y_q + 4'd1;
        ovf_d   = (opr_q == 4'b1000);
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      md_q    <= 1'b0;
      opr_q   <= 4'b0000;
      y_q     <= 4'b0000;
      gnt_q   <= 2'b00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      md_q    <= md_d;
      opr_q   <= opr_d;
      y_q     <= y_d;
      gnt_q   <= gnt_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.gnt  = gnt_q;
  assign bus.y    = y_q;
  assign bus.done = (state_q == DONE);
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_neg_arbiter.sv
// tb_neg_arbiter: directed and random transactions checked against a transaction-level model
module tb_neg_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  neg_arbiter_if bus();
  neg_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m;
  logic [3:0] y_m;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 1;
    y_m = 4'd0;
  endtask
  // one transaction, starting and ending at a negedge in IDLE
  task automatic do_op(input logic [1:0] rq, input logic [3:0] x0, input logic [3:0] x1,
                       input logic [1:0] md, input bit drop);
    int w;
    int lat;
    int a;
    bit m;
    logic [1:0] g;
    bus.req = rq; bus.a0 = x0; bus.a1 = x1; bus.mode = md;
    w = (rq == 2'b11) ? 1 - ptr_m : (rq[1] ? 1 : 0);
    a = w ? int'(x1) : int'(x0);
    m = md[w];
    g = w ? 2'b10 : 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("gnt_cap", 8'(bus.gnt), 8'(g));
    chk("ovf_clr", 8'(bus.ovf), 8'd0);
    chk("done_early", 8'(bus.done), 8'd0);
    if (drop) bus.req = 2'b00;
    bus.a0 = 4'($urandom); bus.a1 = 4'($urandom); bus.mode = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 6);
    chk("latency", 8'(lat), m ? 8'd2 : 8'd1);
    y_m = m ? 4'((16 - a) % 16) : 4'(15 - a);
    chk("y", 8'(bus.y), 8'(y_m));
    chk("ovf", 8'(bus.ovf), (m && a == 8) ? 8'd1 : 8'd0);
    chk("gnt_hold", 8'(bus.gnt), 8'(g));
    ptr_m = w;
    @(negedge clk);
    chk("done_pulse", 8'(bus.done), 8'd0);
    chk("gnt_rel", 8'(bus.gnt), 8'd0);
    chk("y_keep", 8'(bus.y), 8'(y_m));
  endtask
  initial begin
    rst = 1'b1;
    bus.req = 2'b11; bus.a0 = 4'd0; bus.a1 = 4'd0; bus.mode = 2'b00;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 8'(bus.gnt), 8'd0);
      chk("rst_y", 8'(bus.y), 8'd0);
      chk("rst_done", 8'(bus.done), 8'd0);
      chk("rst_ovf", 8'(bus.ovf), 8'd0);
    end
    rst = 1'b0;
    ptr_m = 1;
    y_m = 4'd0;
    do_op(2'b01, 4'b0101, 4'b0000, 2'b00, 1'b1);
    do_op(2'b10, 4'b0000, 4'b0011, 2'b10, 1'b1);
    do_reset();
    repeat (3) do_op(2'b11, 4'b0001, 4'b0010, 2'b00, 1'b0);
    do_op(2'b01, 4'b1000, 4'b0000, 2'b01, 1'b0);
    do_op(2'b01, 4'b0000, 4'b0000, 2'b01, 1'b0);
    do_op(2'b01, 4'b1111, 4'b0000, 2'b01, 1'b0);
    // reset while the increment step is in flight
    bus.req = 2'b01; bus.a0 = 4'b0110; bus.mode = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("abort_gnt", 8'(bus.gnt), 8'd1);
    @(negedge clk);
    chk("abort_inc_done", 8'(bus.done), 8'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_done", 8'(bus.done), 8'd0);
    chk("abort_gnt0", 8'(bus.gnt), 8'd0);
    chk("abort_y", 8'(bus.y), 8'd0);
    rst = 1'b0;
    ptr_m = 1;
    y_m = 4'd0;
    do_op(2'b01, 4'b0110, 4'b0000, 2'b01, 1'b0);
    for (int i = 0; i < 200; i++) begin
      logic [3:0] x0, x1;
      x0 = 4'($urandom);
      x1 = 4'($urandom);
      if ($urandom_range(0, 5) == 0) x0 = 4'b1000;
      if ($urandom_range(0, 5) == 0) x1 = 4'b1000;
      if ($urandom_range(0, 7) == 0) begin
        bus.req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("idle_gnt", 8'(bus.gnt), 8'd0);
        chk("idle_y", 8'(bus.y), 8'(y_m));
      end
      do_op(2'($urandom_range(1, 3)), x0, x1, 2'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
